// File: rtl/spi_xip_pkg.sv
// Shared definitions for the SPI XIP sequencer: spi_top register map, CTRL
// values, bus payload struct, state enums and a byte-swap helper.
package spi_xip_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned SEL_W     = 4;
  localparam int unsigned REG_ADR_W = 5;
  localparam int unsigned FADDR_W   = 22;

  // spi_top register offsets
  localparam logic [REG_ADR_W-1:0] REG_RX0     = 5'h00;
  localparam logic [REG_ADR_W-1:0] REG_TX0     = 5'h00;
  localparam logic [REG_ADR_W-1:0] REG_TX1     = 5'h04;
  localparam logic [REG_ADR_W-1:0] REG_CTRL    = 5'h10;
  localparam logic [REG_ADR_W-1:0] REG_DIVIDER = 5'h14;
  localparam logic [REG_ADR_W-1:0] REG_SS      = 5'h18;

  // ASS | TX_NEG | GO | CHAR_LEN 64
  localparam logic [DATA_W-1:0] CTRL_GO        = 32'h0000_2540;
  localparam int unsigned       CTRL_GO_BIT    = 8;
  localparam logic [7:0]        FLASH_CMD_READ = 8'h03;

  // One register access on the spi_top port
  typedef struct packed {
    logic [REG_ADR_W-1:0] adr;
    logic [DATA_W-1:0]    wdat;
    logic [SEL_W-1:0]     sel;
    logic                 we;
  } spi_req_t;

  typedef enum logic {
    B_IDLE,
    B_BUSY
  } bus_state_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PASS,
    S_X_DIV,
    S_X_TX1,
    S_X_TX0,
    S_X_SS,
    S_X_GO,
    S_X_POLL,
    S_X_RX,
    S_X_SSCLR,
    S_RESP
  } xip_state_e;

  // Flash bytes arrive MSB-first in RX0; APB wants the first byte in the low lane
  function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_xip_busport.sv
// Single register-access engine on the spi_top wishbone-style port.
// A req in idle launches one cycle; stb/cyc are held until ack is sampled,
// then dropped for at least one cycle. done_c/rdat_c/err_c are valid in the
// cycle ack is sampled.
// Ports: clock, reset (async active-low), req, req_pl (payload),
//        done_c, rdat_c, err_c, spi_adr/wdat/sel/we/stb/cyc, spi_rdat/ack/err.
module spi_xip_busport
  import spi_xip_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req,
  input  spi_req_t             req_pl,
  output logic                 done_c,
  output logic [DATA_W-1:0]    rdat_c,
  output logic                 err_c,
  output logic [REG_ADR_W-1:0] spi_adr,
  output logic [DATA_W-1:0]    spi_wdat,
  output logic [SEL_W-1:0]     spi_sel,
  output logic                 spi_we,
  output logic                 spi_stb,
  output logic                 spi_cyc,
  input  logic [DATA_W-1:0]    spi_rdat,
  input  logic                 spi_ack,
  input  logic                 spi_err
);

  bus_state_e state_q, state_d;
  spi_req_t   pl_q, pl_d;
  logic       stb_q, stb_d;

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= B_IDLE;
      pl_q    <= '0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pl_q    <= pl_d;
      stb_q   <= stb_d;
    end
  end

  // Next state: launch on req, release everything on ack
  always_comb begin
    state_d = state_q;
    pl_d    = pl_q;
    stb_d   = stb_q;
    done_c  = 1'b0;
    case (state_q)
      B_IDLE: begin
        if (req) begin
          state_d = B_BUSY;
          pl_d    = req_pl;
          stb_d   = 1'b1;
        end
      end
      B_BUSY: begin
        if (spi_ack) begin
          done_c  = 1'b1;
          state_d = B_IDLE;
          pl_d    = '0;
          stb_d   = 1'b0;
        end
      end
      default: state_d = B_IDLE;
    endcase
  end

  assign spi_adr  = pl_q.adr;
  assign spi_wdat = pl_q.wdat;
  assign spi_sel  = pl_q.sel;
  assign spi_we   = pl_q.we;
  assign spi_stb  = stb_q;
  assign spi_cyc  = stb_q;
  assign rdat_c   = spi_rdat;
  assign err_c    = spi_err;

endmodule

// File: rtl/spi_xip_ctrl.sv
// APB-slot sequencer in front of spi_top. SPI register window accesses are
// forwarded as one bus cycle; flash window reads run the full spi_top
// register sequence (read cmd 0x03 + 24-bit address, 32 data bits) and
// return the byte-swapped word. Flash writes and unmapped addresses get an
// immediate error response.
// Optional feature macro: SPI_XIP_CACHE_EN adds a one-entry read cache.
// Ports: clock, reset (async active-low), APB slave (in_paddr, in_psel,
//        in_penable, in_pwrite, in_pwdata, in_pstrb, in_pready, in_prdata,
//        in_pslverr), spi_top master (spi_adr, spi_wdat, spi_sel, spi_we,
//        spi_stb, spi_cyc, spi_rdat, spi_ack, spi_err).
module spi_xip_ctrl
  import spi_xip_pkg::*;
#(
  parameter logic [ADDR_W-1:0] FLASH_BASE  = 32'h3000_0000,
  parameter logic [ADDR_W-1:0] FLASH_LAST  = 32'h3fff_ffff,
  parameter logic [ADDR_W-1:0] SPI_BASE    = 32'h1000_1000,
  parameter logic [ADDR_W-1:0] SPI_LAST    = 32'h1000_1fff,
  parameter logic [DATA_W-1:0] XIP_DIVIDER = 32'd1,
  parameter logic [7:0]        XIP_SS_MASK = 8'h01
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    in_paddr,
  input  logic                 in_psel,
  input  logic                 in_penable,
  input  logic                 in_pwrite,
  input  logic [DATA_W-1:0]    in_pwdata,
  input  logic [SEL_W-1:0]     in_pstrb,
  output logic                 in_pready,
  output logic [DATA_W-1:0]    in_prdata,
  output logic                 in_pslverr,
  output logic [REG_ADR_W-1:0] spi_adr,
  output logic [DATA_W-1:0]    spi_wdat,
  output logic [SEL_W-1:0]     spi_sel,
  output logic                 spi_we,
  output logic                 spi_stb,
  output logic                 spi_cyc,
  input  logic [DATA_W-1:0]    spi_rdat,
  input  logic                 spi_ack,
  input  logic                 spi_err
);

  xip_state_e        state_q, state_d, step_next;
  logic [23:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d, rx_q, rx_d, prdata_q, prdata_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              we_q, we_d, xerr_q, xerr_d;
  logic              pready_q, pready_d, pslverr_q, pslverr_d;
  logic              xip_step;

  logic              bus_req_c, bus_done_c, bus_err_c;
  spi_req_t          bus_pl_c;
  logic [DATA_W-1:0] bus_rdat_c;

  logic              setup_c, spi_win_c, flash_win_c;
  logic              cache_hit_c;
  logic [DATA_W-1:0] cache_data_c;

  assign setup_c     = in_psel && !in_penable;
  assign spi_win_c   = (in_paddr >= SPI_BASE) && (in_paddr <= SPI_LAST);
  assign flash_win_c = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_LAST);

`ifdef SPI_XIP_CACHE_EN
  logic               c_valid_q;
  logic [FADDR_W-1:0] c_tag_q;
  logic [DATA_W-1:0]  c_data_q;

  // Fill on a clean XIP completion; drop on any forwarded write
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      c_valid_q <= 1'b0;
      c_tag_q   <= '0;
      c_data_q  <= '0;
    end else if (state_q == S_X_SSCLR && bus_done_c && !xerr_q && !bus_err_c) begin
      c_valid_q <= 1'b1;
      c_tag_q   <= addr_q[23:2];
      c_data_q  <= byte_swap(rx_q);
    end else if (state_q == S_IDLE && setup_c && spi_win_c && in_pwrite) begin
      c_valid_q <= 1'b0;
    end
  end

  assign cache_hit_c  = c_valid_q && (c_tag_q == in_paddr[23:2]);
  assign cache_data_c = c_data_q;
`else
  assign cache_hit_c  = 1'b0;
  assign cache_data_c = '0;
`endif

  spi_xip_busport u_busport (
    .clock    (clock),
    .reset    (reset),
    .req      (bus_req_c),
    .req_pl   (bus_pl_c),
    .done_c   (bus_done_c),
    .rdat_c   (bus_rdat_c),
    .err_c    (bus_err_c),
    .spi_adr  (spi_adr),
    .spi_wdat (spi_wdat),
    .spi_sel  (spi_sel),
    .spi_we   (spi_we),
    .spi_stb  (spi_stb),
    .spi_cyc  (spi_cyc),
    .spi_rdat (spi_rdat),
    .spi_ack  (spi_ack),
    .spi_err  (spi_err)
  );

  // State, latched request and APB response registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdat_q    <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      rx_q      <= '0;
      xerr_q    <= 1'b0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      rx_q      <= rx_d;
      xerr_q    <= xerr_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  // Decode, PASS forwarding and the XIP step table
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    rx_d      = rx_q;
    xerr_d    = xerr_q;
    pready_d  = 1'b0;
    prdata_d  = '0;
    pslverr_d = 1'b0;
    bus_req_c = 1'b0;
    bus_pl_c  = '{adr: '0, wdat: '0, sel: 4'hf, we: 1'b0};
    step_next = S_IDLE;
    xip_step  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (setup_c) begin
          addr_d = in_paddr[23:0];
          wdat_d = in_pwdata;
          sel_d  = in_pstrb;
          we_d   = in_pwrite;
          if (spi_win_c) begin
            state_d = S_PASS;
          end else if (flash_win_c && !in_pwrite) begin
            if (cache_hit_c) begin
              pready_d = 1'b1;
              prdata_d = cache_data_c;
              state_d  = S_RESP;
            end else begin
              xerr_d  = 1'b0;
              state_d = S_X_DIV;
            end
          end else begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            state_d   = S_RESP;
          end
        end
      end
      S_PASS: begin
        bus_req_c = 1'b1;
        bus_pl_c  = '{adr: addr_q[4:0], wdat: wdat_q, sel: sel_q, we: we_q};
        if (bus_done_c) begin
          pready_d  = 1'b1;
          prdata_d  = bus_rdat_c;
          pslverr_d = bus_err_c;
          state_d   = S_RESP;
        end
      end
      S_X_DIV: begin
        xip_step      = 1'b1;
        bus_pl_c.adr  = REG_DIVIDER;
        bus_pl_c.we   = 1'b1;
        bus_pl_c.wdat = XIP_DIVIDER;
        step_next     = S_X_TX1;
      end
      S_X_TX1: begin
        xip_step      = 1'b1;
        bus_pl_c.adr  = REG_TX1;
        bus_pl_c.we   = 1'b1;
        bus_pl_c.wdat = {FLASH_CMD_READ, addr_q[23:2], 2'b00};
        step_next     = S_X_TX0;
      end
      S_X_TX0: begin
        xip_step      = 1'b1;
        bus_pl_c.adr  = REG_TX0;
        bus_pl_c.we   = 1'b1;
        step_next     = S_X_SS;
      end
      S_X_SS: begin
        xip_step      = 1'b1;
        bus_pl_c.adr  = REG_SS;
        bus_pl_c.we   = 1'b1;
        bus_pl_c.wdat = 32'(XIP_SS_MASK);
        step_next     = S_X_GO;
      end
      S_X_GO: begin
        xip_step      = 1'b1;
        bus_pl_c.adr  = REG_CTRL;
        bus_pl_c.we   = 1'b1;
        bus_pl_c.wdat = CTRL_GO;
        step_next     = S_X_POLL;
      end
      S_X_POLL: begin
        xip_step     = 1'b1;
        bus_pl_c.adr = REG_CTRL;
        step_next    = bus_rdat_c[CTRL_GO_BIT] ? S_X_POLL : S_X_RX;
      end
      S_X_RX: begin
        xip_step     = 1'b1;
        bus_pl_c.adr = REG_RX0;
        step_next    = S_X_SSCLR;
        if (bus_done_c) rx_d = bus_rdat_c;
      end
      S_X_SSCLR: begin
        xip_step     = 1'b1;
        bus_pl_c.adr = REG_SS;
        bus_pl_c.we  = 1'b1;
        step_next    = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Common XIP step completion: an error at any step skips ahead to SS clear
    if (xip_step) begin
      bus_req_c = 1'b1;
      if (bus_done_c) begin
        if (state_q == S_X_SSCLR) begin
          pready_d  = 1'b1;
          pslverr_d = xerr_q || bus_err_c;
          prdata_d  = (xerr_q || bus_err_c) ? '0 : byte_swap(rx_q);
          state_d   = S_RESP;
        end else if (bus_err_c) begin
          xerr_d  = 1'b1;
          state_d = S_X_SSCLR;
        end else begin
          state_d = step_next;
        end
      end
    end
  end

  assign in_pready  = pready_q;
  assign in_prdata  = prdata_q;
  assign in_pslverr = pslverr_q;

endmodule

// File: tb/tb_spi_xip_ctrl.sv
// Directed self-checking bench for spi_xip_ctrl with a small spi_top model.
module tb_spi_xip_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_paddr = '0;
  logic        in_psel = 1'b0;
  logic        in_penable = 1'b0;
  logic        in_pwrite = 1'b0;
  logic [31:0] in_pwdata = '0;
  logic [3:0]  in_pstrb = '0;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;
  logic [4:0]  spi_adr;
  logic [31:0] spi_wdat;
  logic [3:0]  spi_sel;
  logic        spi_we, spi_stb, spi_cyc;
  logic [31:0] spi_rdat;
  logic        spi_ack, spi_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  spi_xip_ctrl dut (
    .clock(clock), .reset(reset),
    .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable),
    .in_pwrite(in_pwrite), .in_pwdata(in_pwdata), .in_pstrb(in_pstrb),
    .in_pready(in_pready), .in_prdata(in_prdata), .in_pslverr(in_pslverr),
    .spi_adr(spi_adr), .spi_wdat(spi_wdat), .spi_sel(spi_sel), .spi_we(spi_we),
    .spi_stb(spi_stb), .spi_cyc(spi_cyc), .spi_rdat(spi_rdat),
    .spi_ack(spi_ack), .spi_err(spi_err)
  );

  // spi_top model: ack one cycle after stb; GO reads 1 for go_polls CTRL reads after a CTRL write
  int          go_polls = 0;
  int          ctrl_reads = 0;
  logic [31:0] rx_word = '0;
  logic        err_en = 1'b0;
  logic [4:0]  err_adr = '0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      spi_ack <= 1'b0; spi_err <= 1'b0; spi_rdat <= '0; ctrl_reads <= 0;
    end else if (spi_stb && spi_cyc && !spi_ack) begin
      spi_ack <= 1'b1;
      spi_err <= err_en && (spi_adr == err_adr);
      spi_rdat <= '0;
      if (spi_adr == 5'h10 && spi_we) ctrl_reads <= 0;
      if (spi_adr == 5'h10 && !spi_we) begin
        spi_rdat   <= (ctrl_reads < go_polls) ? 32'h0000_2540 : 32'h0000_2440;
        ctrl_reads <= ctrl_reads + 1;
      end
      if (spi_adr == 5'h00 && !spi_we) spi_rdat <= rx_word;
    end else begin
      spi_ack <= 1'b0; spi_err <= 1'b0;
    end
  end

  // Bus monitor: log each spi cycle at its first stb cycle; count pready cycles
  logic [4:0]  log_adr [64];
  logic        log_we  [64];
  logic [31:0] log_wdat[64];
  logic [3:0]  log_sel [64];
  int          log_n = 0;
  int          pready_cnt = 0;
  logic        stb_prev = 1'b0;

  always @(negedge clock) begin
    if (spi_stb && !stb_prev) begin
      log_adr[log_n % 64]  <= spi_adr;
      log_we[log_n % 64]   <= spi_we;
      log_wdat[log_n % 64] <= spi_wdat;
      log_sel[log_n % 64]  <= spi_sel;
      log_n <= log_n + 1;
    end
    stb_prev <= spi_stb;
    if (in_pready) pready_cnt <= pready_cnt + 1;
  end

  // One APB transfer; lat = cycles from the end of setup to pready (-1 on timeout)
  task automatic apb(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output logic er,
                     output int lat);
    @(posedge clock); #1;
    in_paddr = a; in_pwrite = w; in_pwdata = d; in_pstrb = s;
    in_psel = 1'b1; in_penable = 1'b0;
    @(posedge clock); #1;
    in_penable = 1'b1;
    lat = 0; rd = '0; er = 1'b0;
    forever begin
      @(negedge clock);
      lat++;
      if (in_pready) begin rd = in_prdata; er = in_pslverr; break; end
      if (lat > 2000) begin lat = -1; break; end
    end
    @(posedge clock); #1;
    in_psel = 1'b0; in_penable = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    n_tests++;
    if ({in_pready, in_prdata, in_pslverr, spi_adr, spi_wdat, spi_sel, spi_we, spi_stb, spi_cyc} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: pready=%b prdata=%h pslverr=%b stb=%b adr=%h required all 0",
               in_pready, in_prdata, in_pslverr, spi_stb, spi_adr);
    end
    reset = 1'b1;
    repeat (2) @(posedge clock);
  endtask

  task automatic test_pass();
    logic [31:0] rd; logic er; int lat, base, pc;
    base = log_n; pc = pready_cnt;
    apb(32'h1000_1014, 1'b1, 32'h5, 4'hf, rd, er, lat);
    repeat (3) @(posedge clock);
    #1;
    n_tests++;
    if (lat < 0 || er !== 1'b0) begin n_fail++; $display("FAIL pass_wr_resp: lat=%0d err=%b required err 0", lat, er); end
    n_tests++;
    if (log_n - base !== 1) begin n_fail++; $display("FAIL pass_wr_cycles: got %0d required 1", log_n - base); end
    n_tests++;
    if ({log_adr[base % 64], log_we[base % 64], log_wdat[base % 64], log_sel[base % 64]} !== {5'h14, 1'b1, 32'h5, 4'hf}) begin
      n_fail++;
      $display("FAIL pass_wr_bus: adr=%h we=%b wdat=%h sel=%h required 14 1 00000005 f",
               log_adr[base % 64], log_we[base % 64], log_wdat[base % 64], log_sel[base % 64]);
    end
    n_tests++;
    if (pready_cnt - pc !== 1) begin n_fail++; $display("FAIL pass_wr_pready_pulse: got %0d cycles required 1", pready_cnt - pc); end
    // forwarded read with partial strobes
    base = log_n;
    apb(32'h1000_1010, 1'b0, 32'h0, 4'h3, rd, er, lat);
    n_tests++;
    if (rd !== 32'h0000_2440 || er !== 1'b0) begin n_fail++; $display("FAIL pass_rd_data: got %h err=%b required 00002440 err 0", rd, er); end
    n_tests++;
    if ({log_adr[base % 64], log_we[base % 64], log_sel[base % 64]} !== {5'h10, 1'b0, 4'h3}) begin
      n_fail++;
      $display("FAIL pass_rd_bus: adr=%h we=%b sel=%h required 10 0 3", log_adr[base % 64], log_we[base % 64], log_sel[base % 64]);
    end
    // spi_err is reflected as pslverr
    err_en = 1'b1; err_adr = 5'h18;
    apb(32'h1000_1018, 1'b1, 32'h1, 4'hf, rd, er, lat);
    err_en = 1'b0;
    n_tests++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL pass_err: got pslverr=%b required 1", er); end
  endtask

  task automatic test_xip_read();
    logic [31:0] rd; logic er; int lat, base;
    logic [4:0]  ea [8];
    logic        ew [8];
    logic [31:0] ed [8];
    ea = '{5'h14, 5'h04, 5'h00, 5'h18, 5'h10, 5'h10, 5'h00, 5'h18};
    ew = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    ed = '{32'h1, 32'h0300_0104, 32'h0, 32'h1, 32'h2540, 32'h0, 32'h0, 32'h0};
    go_polls = 0; rx_word = 32'hAABB_CCDD;
    base = log_n;
    apb(32'h3000_0104, 1'b0, 32'h0, 4'h0, rd, er, lat);
    n_tests++;
    if (lat < 0 || rd !== 32'hDDCC_BBAA || er !== 1'b0) begin
      n_fail++; $display("FAIL xip_rd_data: lat=%0d got %h err=%b required ddccbbaa err 0", lat, rd, er);
    end
    n_tests++;
    if (log_n - base !== 8) begin n_fail++; $display("FAIL xip_rd_cycles: got %0d required 8", log_n - base); end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if ({log_adr[(base + i) % 64], log_we[(base + i) % 64], log_sel[(base + i) % 64],
           log_we[(base + i) % 64] ? log_wdat[(base + i) % 64] : 32'h0} !==
          {ea[i], ew[i], 4'hf, ed[i]}) begin
        n_fail++;
        $display("FAIL xip_rd_step%0d: adr=%h we=%b sel=%h wdat=%h required %h %b f %h", i,
                 log_adr[(base + i) % 64], log_we[(base + i) % 64], log_sel[(base + i) % 64],
                 log_wdat[(base + i) % 64], ea[i], ew[i], ed[i]);
      end
    end
  endtask

  task automatic test_bad_access();
    logic [31:0] rd; logic er; int lat, base;
    base = log_n;
    apb(32'h3000_0000, 1'b1, 32'h1234_5678, 4'hf, rd, er, lat);
    n_tests++;
    if ({lat, er, rd} !== {32'd1, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL flash_write: lat=%0d err=%b rd=%h required 1 1 0", lat, er, rd);
    end
    apb(32'h2000_0000, 1'b0, 32'h0, 4'hf, rd, er, lat);
    n_tests++;
    if ({lat, er, rd} !== {32'd1, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL unmapped: lat=%0d err=%b rd=%h required 1 1 0", lat, er, rd);
    end
    n_tests++;
    if (log_n !== base) begin n_fail++; $display("FAIL bad_no_spi: got %0d cycles required 0", log_n - base); end
  endtask

  task automatic test_poll();
    logic [31:0] rd; logic er; int lat, base, nctrl, last;
    go_polls = 5; rx_word = 32'h1122_3344;
    base = log_n;
    apb(32'h3000_0200, 1'b0, 32'h0, 4'hf, rd, er, lat);
    go_polls = 0;
    nctrl = 0; last = -1;
    for (int i = base; i < log_n; i++) begin
      if (log_adr[i % 64] == 5'h10 && !log_we[i % 64]) begin nctrl++; last = i; end
    end
    n_tests++;
    if (nctrl !== 6) begin n_fail++; $display("FAIL poll_count: got %0d ctrl reads required 6", nctrl); end
    n_tests++;
    if (last < 0 || log_adr[(last + 1) % 64] !== 5'h00 || log_we[(last + 1) % 64] !== 1'b0) begin
      n_fail++; $display("FAIL poll_then_rx: next adr=%h we=%b required 00 0", log_adr[(last + 1) % 64], log_we[(last + 1) % 64]);
    end
    n_tests++;
    if (rd !== 32'h4433_2211 || er !== 1'b0 || log_n - base !== 13) begin
      n_fail++; $display("FAIL poll_resp: got %h err=%b cycles=%0d required 44332211 0 13", rd, er, log_n - base);
    end
  endtask

  task automatic test_xip_err();
    logic [31:0] rd; logic er; int lat, base;
    err_en = 1'b1; err_adr = 5'h04;
    base = log_n;
    apb(32'h3000_0300, 1'b0, 32'h0, 4'hf, rd, er, lat);
    err_en = 1'b0;
    n_tests++;
    if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL xip_err_resp: err=%b rd=%h required 1 0", er, rd); end
    n_tests++;
    if (log_n - base !== 3 || log_adr[(base + 2) % 64] !== 5'h18 || log_wdat[(base + 2) % 64] !== 32'h0) begin
      n_fail++; $display("FAIL xip_err_abort: cycles=%0d last adr=%h wdat=%h required 3 18 0",
                         log_n - base, log_adr[(base + 2) % 64], log_wdat[(base + 2) % 64]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat, base, pc; logic found;
    go_polls = 1000; rx_word = 32'hAABB_CCDD;
    base = log_n;
    @(posedge clock); #1;
    in_paddr = 32'h3000_0104; in_pwrite = 1'b0; in_psel = 1'b1; in_penable = 1'b0;
    @(posedge clock); #1;
    in_penable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clock);
      if (log_n > base + 5) found = 1'b1;
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL reset_mid_reach_poll: got %0d cycles required 6", log_n - base); end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({in_pready, in_prdata, in_pslverr, spi_adr, spi_wdat, spi_sel, spi_we, spi_stb, spi_cyc} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: stb=%b adr=%h pready=%b required all 0", spi_stb, spi_adr, in_pready);
    end
    in_psel = 1'b0; in_penable = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    go_polls = 0;
    pc = pready_cnt;
    repeat (6) @(posedge clock);
    #1;
    n_tests++;
    if (pready_cnt !== pc) begin n_fail++; $display("FAIL reset_mid_spurious: got %0d pready cycles required 0", pready_cnt - pc); end
    apb(32'h3000_0104, 1'b0, 32'h0, 4'hf, rd, er, lat);
    repeat (2) @(posedge clock);
    #1;
    n_tests++;
    if (rd !== 32'hDDCC_BBAA || er !== 1'b0 || pready_cnt - pc !== 1) begin
      n_fail++; $display("FAIL reset_mid_recover: got %h err=%b pulses=%0d required ddccbbaa 0 1", rd, er, pready_cnt - pc);
    end
  endtask

  task automatic test_cache();
    logic [31:0] rd; logic er; int lat, base;
    rx_word = 32'hAABB_CCDD; go_polls = 0;
    apb(32'h3000_0104, 1'b0, 32'h0, 4'hf, rd, er, lat);
    base = log_n;
    apb(32'h3000_0104, 1'b0, 32'h0, 4'hf, rd, er, lat);
    n_tests++;
    if (rd !== 32'hDDCC_BBAA || er !== 1'b0) begin n_fail++; $display("FAIL repeat_rd_data: got %h err=%b required ddccbbaa 0", rd, er); end
`ifdef SPI_XIP_CACHE_EN
    n_tests++;
    if (log_n - base !== 0 || lat !== 1) begin
      n_fail++; $display("FAIL cache_hit: cycles=%0d lat=%0d required 0 1", log_n - base, lat);
    end
`else
    n_tests++;
    if (log_n - base !== 8) begin n_fail++; $display("FAIL repeat_rd_full: got %0d cycles required 8", log_n - base); end
`endif
    apb(32'h1000_1014, 1'b1, 32'h1, 4'hf, rd, er, lat);
    base = log_n;
    apb(32'h3000_0104, 1'b0, 32'h0, 4'hf, rd, er, lat);
    n_tests++;
    if (log_n - base !== 8 || rd !== 32'hDDCC_BBAA) begin
      n_fail++; $display("FAIL rd_after_pass_wr: cycles=%0d rd=%h required 8 ddccbbaa", log_n - base, rd);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_xip_read();
    test_bad_access();
    test_poll();
    test_xip_err();
    test_reset_mid();
    test_cache();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
